// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bnj branch/jump class codes (also used by the
// control decoder), PC sequencer FSM state encoding and a small helper.
package cpu_pkg;

    // Branch/jump class codes {bnj1,bnj2,bnj3}
    localparam logic [2:0] BNJ_SEQ  = 3'b000;
    localparam logic [2:0] BNJ_J    = 3'b001;
    localparam logic [2:0] BNJ_BEQ  = 3'b010;
    localparam logic [2:0] BNJ_BGEZ = 3'b011;
    localparam logic [2:0] BNJ_BRN  = 3'b100;
    localparam logic [2:0] BNJ_JM   = 3'b101;
    localparam logic [2:0] BNJ_BALZ = 3'b110;
    localparam logic [2:0] BNJ_ILL  = 3'b111;

    // PC sequencer FSM
    typedef enum logic {
        StRun    = 1'b0,
        StJmWait = 1'b1
    } pc_state_e;

    // Force a 32-bit address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Branch and jump target arithmetic for the PC sequencer (modulo 2^32).
module pc_target_calc (
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm,
    input  logic [25:0] jidx,
    output logic [31:0] btarget,
    output logic [31:0] jtarget
);

    // Branch: word offset relative to pc+4; jump: region of pc+4 plus index
    always_comb begin
        btarget = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
        jtarget = {pc_plus4[31:28], jidx, 2'b00};
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: PC register, status flags and a RUN/JM_WAIT FSM that picks
// the next PC from the bnj class. Memory-indirect jumps (jm) stall until the
// data memory returns the target.
// Optional feature: define BNJ_ILLEGAL_TRAP_EN to vector illegal bnj codes to
// TRAP_VECTOR; otherwise they fall through to pc+4 (illegal still flagged).
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  bnj,
    input  logic [15:0] imm,
    input  logic [25:0] jidx,
    input  logic [31:0] rs_val,
    input  logic        zero,
    input  logic        neg,
    input  logic        status_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        stall,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        illegal
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        sz_q, sn_q;
    logic [31:0] btarget, jtarget;

    // sz is kept for the architectural status register but no branch reads it
    logic unused_bits;
    assign unused_bits = ^{sz_q, rs_val[1:0], mem_rdata[1:0]};

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign link_data = pc_plus4;

    pc_target_calc u_target (
        .pc_plus4 (pc_plus4),
        .imm      (imm),
        .jidx     (jidx),
        .btarget  (btarget),
        .jtarget  (jtarget)
    );

    // Next-state, next-pc and control outputs
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stall   = 1'b0;
        link_we = 1'b0;
        illegal = 1'b0;

        unique case (state_q)
            StRun: begin
                pc_d = pc_plus4;
                case (bnj)
                    BNJ_SEQ:  pc_d = pc_plus4;
                    BNJ_J:    pc_d = jtarget;
                    BNJ_BEQ:  pc_d = zero ? btarget : pc_plus4;
                    BNJ_BGEZ: pc_d = neg ? pc_plus4 : btarget;
                    // brn uses the registered flag, so a coincident status_we
                    // only affects the following cycle
                    BNJ_BRN:  pc_d = sn_q ? word_align(rs_val) : pc_plus4;
                    BNJ_JM: begin
                        pc_d    = pc_q;
                        stall   = 1'b1;
                        state_d = StJmWait;
                    end
                    BNJ_BALZ: begin
                        pc_d    = zero ? jtarget : pc_plus4;
                        link_we = zero;
                    end
                    BNJ_ILL: begin
                        illegal = 1'b1;
`ifdef BNJ_ILLEGAL_TRAP_EN
                        pc_d    = TRAP_VECTOR;
`else
                        pc_d    = pc_plus4;
`endif
                    end
                    default: ;
                endcase
            end
            StJmWait: begin
                if (mem_rvalid) begin
                    pc_d    = word_align(mem_rdata);
                    state_d = StRun;
                end else begin
                    stall = 1'b1;
                end
            end
            default: ;
        endcase

        // Reset quiets all control outputs regardless of state
        if (reset) begin
            stall   = 1'b0;
            link_we = 1'b0;
            illegal = 1'b0;
        end
    end

    // FSM and PC registers, synchronous reset abandons any pending jm
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Status flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            sz_q <= 1'b0;
            sn_q <= 1'b0;
        end else if (status_we) begin
            sz_q <= zero;
            sn_q <= neg;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: an abstract PC model checked every
// cycle plus directed scenarios with literal expectations.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_PC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  bnj;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] rs_val;
    logic        zero, neg, status_we;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [31:0] pc, pc_plus4, link_data;
    logic        stall, link_we, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(
        .RESET_PC    (RST_PC),
        .TRAP_VECTOR (TRAP_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bnj        (bnj),
        .imm        (imm),
        .jidx       (jidx),
        .rs_val     (rs_val),
        .zero       (zero),
        .neg        (neg),
        .status_we  (status_we),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .stall      (stall),
        .link_we    (link_we),
        .link_data  (link_data),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_wait;
    logic        m_sn;
    logic        m_valid = 1'b0;

    function automatic logic [31:0] m_btarget(input logic [31:0] p, input logic [15:0] i);
        logic signed [31:0] off;
        off = $signed(i);
        return p + 32'd4 + off * 4;
    endfunction

    function automatic logic [31:0] m_jtarget(input logic [31:0] p, input logic [25:0] j);
        return ((p + 32'd4) & 32'hF000_0000) | ({6'd0, j} << 2);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc    = RST_PC;
            m_wait  = 1'b0;
            m_sn    = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_wait) begin
                if (mem_rvalid) begin
                    m_pc   = mem_rdata & 32'hFFFF_FFFC;
                    m_wait = 1'b0;
                end
            end else begin
                case (bnj)
                    3'd1: m_pc = m_jtarget(m_pc, jidx);
                    3'd2: m_pc = zero ? m_btarget(m_pc, imm) : m_pc + 32'd4;
                    3'd3: m_pc = !neg ? m_btarget(m_pc, imm) : m_pc + 32'd4;
                    3'd4: m_pc = m_sn ? (rs_val & 32'hFFFF_FFFC) : m_pc + 32'd4;
                    3'd5: m_wait = 1'b1;
                    3'd6: m_pc = zero ? m_jtarget(m_pc, jidx) : m_pc + 32'd4;
`ifdef BNJ_ILLEGAL_TRAP_EN
                    3'd7: m_pc = TRAP_PC;
`endif
                    default: m_pc = m_pc + 32'd4;
                endcase
            end
            if (status_we) m_sn = neg;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc", pc, m_pc);
            chk("model_pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("model_link_data", link_data, m_pc + 32'd4);
            chk("model_stall", {31'd0, stall},
                {31'd0, !reset && (m_wait ? !mem_rvalid : (bnj == 3'd5))});
            chk("model_link_we", {31'd0, link_we},
                {31'd0, !reset && !m_wait && (bnj == 3'd6) && zero});
            chk("model_illegal", {31'd0, illegal},
                {31'd0, !reset && !m_wait && (bnj == 3'd7)});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [25:0] idx);
        bnj  = 3'd1;
        jidx = idx;
        tick();
        bnj  = 3'd0;
    endtask

    int n_stall;

    initial begin
        reset = 1'b1; bnj = 3'd0; imm = '0; jidx = '0; rs_val = '0;
        zero = 1'b0; neg = 1'b0; status_we = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
        tick();
        tick();
        // Outputs quiet while reset is high, whatever bnj says
        bnj = 3'd6; zero = 1'b1; #1;
        chk("rst_link_we", {31'd0, link_we}, 32'd0);
        bnj = 3'd5; #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        bnj = 3'd7; #1;
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_pc", pc, 32'h0);

        // Sequential fetch
        reset = 1'b0; bnj = 3'd0; zero = 1'b0;
        tick(); chk("seq_pc1", pc, 32'h4);
        tick(); chk("seq_pc2", pc, 32'h8);
        tick(); chk("seq_pc3", pc, 32'hC);

        // beq taken / not taken
        jump_to(26'h40); chk("j_pc", pc, 32'h100);
        bnj = 3'd2; imm = 16'hFFFE; zero = 1'b1; tick();
        chk("beq_taken", pc, 32'hFC);
        jump_to(26'h40);
        bnj = 3'd2; zero = 1'b0; tick();
        chk("beq_not_taken", pc, 32'h104);

        // bgez
        jump_to(26'h40);
        bnj = 3'd3; imm = 16'h0010; neg = 1'b0; tick();
        chk("bgez_taken", pc, 32'h144);
        bnj = 3'd3; neg = 1'b1; tick();
        chk("bgez_not_taken", pc, 32'h148);
        neg = 1'b0;

        // balz with link
        jump_to(26'h80); chk("j_pc_200", pc, 32'h200);
        bnj = 3'd6; zero = 1'b1; jidx = 26'h40; #1;
        chk("balz_link_we", {31'd0, link_we}, 32'd1);
        chk("balz_link_data", link_data, 32'h204);
        tick(); chk("balz_pc", pc, 32'h100);
        bnj = 3'd6; zero = 1'b0; #1;
        chk("balz_nt_link_we", {31'd0, link_we}, 32'd0);
        tick(); chk("balz_nt_pc", pc, 32'h104);

        // brn with registered status flag
        jump_to(26'h40);
        status_we = 1'b1; neg = 1'b1; tick();
        status_we = 1'b0; neg = 1'b0; bnj = 3'd4; rs_val = 32'h303; tick();
        chk("brn_taken", pc, 32'h300);
        bnj = 3'd0; status_we = 1'b1; neg = 1'b0; tick();
        chk("brn_clear_pc", pc, 32'h304);
        bnj = 3'd4; status_we = 1'b1; neg = 1'b1; tick();
        chk("brn_old_sn", pc, 32'h308);
        bnj = 3'd4; status_we = 1'b0; neg = 1'b0; tick();
        chk("brn_new_sn", pc, 32'h300);
        bnj = 3'd0;

        // jm: three idle wait cycles then data
        jump_to(26'h40);
        n_stall = 0;
        bnj = 3'd5; mem_rvalid = 1'b0; #1;
        if (stall) n_stall++;
        tick();
        bnj = 3'd6; zero = 1'b1; #1;
        chk("jm_wait_link_we", {31'd0, link_we}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (stall) n_stall++;
            chk("jm_hold_pc", pc, 32'h100);
            tick();
        end
        mem_rdata = 32'h1237; mem_rvalid = 1'b1; #1;
        chk("jm_stall_drop", {31'd0, stall}, 32'd0);
        if (stall) n_stall++;
        tick();
        mem_rvalid = 1'b0; bnj = 3'd0; zero = 1'b0;
        chk("jm_stall_cycles", n_stall, 32'd4);
        chk("jm_pc", pc, 32'h1234);

        // Reset during a jm wait
        bnj = 3'd5; tick();
        bnj = 3'd0; #1;
        chk("jm2_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1; tick();
        reset = 1'b0; #1;
        chk("jm_rst_pc", pc, RST_PC);
        chk("jm_rst_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("jm_rst_run", pc, RST_PC + 32'd4);

        // Illegal bnj
        jump_to(26'h40);
        bnj = 3'd7; #1;
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        tick();
`ifdef BNJ_ILLEGAL_TRAP_EN
        chk("ill_pc", pc, TRAP_PC);
`else
        chk("ill_pc", pc, 32'h104);
`endif
        bnj = 3'd0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
